// File: rtl/phy_traffic_bist_pkg.sv
// Shared definitions for the PHY traffic BIST: state encodings, pattern and gap helpers.
// Optional feature macro: PHY_BIST_ERRLOG_EN (see phy_traffic_bist.sv).
package phy_traffic_bist_pkg;

  typedef enum logic [1:0] {GEN_IDLE, GEN_SEND, GEN_DRAIN, GEN_DONE} gen_state_t;
  typedef enum logic {CHK_HUNT, CHK_LOCKED} chk_state_t;

  // Nibble for pattern index idx = k % PAT_LEN; the word replicates it DATA_W/4 times.
  function automatic logic [3:0] pat_nibble(input int unsigned idx);
    return 4'hF - idx[3:0];
  endfunction

  function automatic logic is_gap(input int unsigned pos, input int unsigned gap_start,
                                  input int unsigned gap_len);
    return (pos >= gap_start) && (pos < gap_start + gap_len);
  endfunction

endpackage

// File: rtl/phy_traffic_bist_if.sv
// PHY data path between the BIST (master) and the PHY transmit/receive sides (slave).
interface phy_traffic_bist_if #(parameter int unsigned DATA_W = 32);
  logic [DATA_W-1:0] data_in;
  logic              valid_in;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;

  modport master (output data_in, output valid_in, input data_out, input valid_out);
  modport slave  (input data_in, input valid_in, output data_out, output valid_out);
endinterface

// File: rtl/phy_traffic_bist_checker.sv
// Return-path checker: hunts for pattern start, then compares every valid word.
// PHY_BIST_ERRLOG_EN adds first-mismatch capture outputs.
module phy_bist_checker
  import phy_traffic_bist_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned PAT_LEN   = 4,
  parameter int unsigned PERIOD    = 8,
  parameter int unsigned GAP_START = 4,
  parameter int unsigned GAP_LEN   = 2,
  parameter int unsigned ERR_W     = 16,
  parameter int unsigned RXW       = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] data,
  input  logic              valid,
  input  logic [RXW-1:0]    expected,
  output logic              locked,
  output logic [RXW-1:0]    rx_count,
  output logic [ERR_W-1:0]  err_count
`ifdef PHY_BIST_ERRLOG_EN
  ,
  output logic [DATA_W-1:0] first_exp,
  output logic [DATA_W-1:0] first_got,
  output logic [15:0]       first_idx
`endif
);

  localparam int unsigned PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int unsigned IW = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1;

  chk_state_t        state, state_nxt;
  logic [PW-1:0]     pos, pos_nxt;
  logic [IW-1:0]     pid, pid_nxt;
  logic [DATA_W-1:0] exp_word;
  logic [DATA_W-1:0] pat0;
  logic              take, hit0, bad;

  assign exp_word = {(DATA_W/4){pat_nibble(32'(pid))}};
  assign pat0     = {(DATA_W/4){4'hF}};
  assign take     = en && valid;
  assign hit0     = (data == pat0);
  assign bad      = (data != exp_word) || (rx_count >= expected);
  assign locked   = (state == CHK_LOCKED);

  // k_exp is tracked as (k % PERIOD, k % PAT_LEN); a step landing on the gap jumps past it.
  always_comb begin
    pos_nxt = (pos == PW'(PERIOD - 1)) ? '0 : pos + 1'b1;
    pid_nxt = (pid == IW'(PAT_LEN - 1)) ? '0 : pid + 1'b1;
    if (GAP_LEN != 0 && pos_nxt == PW'(GAP_START)) begin
      pos_nxt = PW'((GAP_START + GAP_LEN) % PERIOD);
      pid_nxt = IW'((32'(pid) + GAP_LEN + 1) % PAT_LEN);
    end
  end

  always_comb begin
    state_nxt = state;
    if (clr)
      state_nxt = CHK_HUNT;
    else if (state == CHK_HUNT && take && hit0)
      state_nxt = CHK_LOCKED;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= CHK_HUNT;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_count  <= '0;
      err_count <= '0;
      pos       <= '0;
      pid       <= '0;
    end else if (clr) begin
      rx_count  <= '0;
      err_count <= '0;
      pos       <= '0;
      pid       <= '0;
    end else if (take) begin
      if (state == CHK_HUNT) begin
        if (hit0) begin
          rx_count <= RXW'(1);
          pos      <= pos_nxt;
          pid      <= pid_nxt;
        end
      end else begin
        rx_count <= (rx_count == '1) ? rx_count : rx_count + 1'b1;
        pos      <= pos_nxt;
        pid      <= pid_nxt;
        if (bad && err_count != '1)
          err_count <= err_count + 1'b1;
      end
    end
  end

`ifdef PHY_BIST_ERRLOG_EN
  logic logged;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      logged    <= 1'b0;
      first_exp <= '0;
      first_got <= '0;
      first_idx <= '0;
    end else if (clr) begin
      logged    <= 1'b0;
      first_exp <= '0;
      first_got <= '0;
      first_idx <= '0;
    end else if (take && state == CHK_LOCKED && bad && !logged) begin
      logged    <= 1'b1;
      first_exp <= exp_word;
      first_got <= data;
      first_idx <= 16'(rx_count);
    end
  end
`endif

endmodule

// File: rtl/phy_traffic_bist.sv
// PHY traffic BIST top: pattern generator FSM, drain timer, pass logic, checker instance.
// Define PHY_BIST_ERRLOG_EN to expose first_exp/first_got/first_idx.
module phy_traffic_bist
  import phy_traffic_bist_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned PAT_LEN   = 4,
  parameter int unsigned PERIOD    = 8,
  parameter int unsigned GAP_START = 4,
  parameter int unsigned GAP_LEN   = 2,
  parameter int unsigned ERR_W     = 16,
  parameter int unsigned DRAIN_MAX = 256
) (
  input  logic                clk_2f,
  input  logic                reset,
  input  logic                start,
  input  logic [15:0]         burst_count,
  phy_traffic_bist_if.master  phy,
  output logic                busy,
  output logic                done,
  output logic                locked,
  output logic                pass,
  output logic [ERR_W-1:0]    err_count
`ifdef PHY_BIST_ERRLOG_EN
  ,
  output logic [DATA_W-1:0]   first_exp,
  output logic [DATA_W-1:0]   first_got,
  output logic [15:0]         first_idx
`endif
);

  localparam int unsigned PW  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int unsigned IW  = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1;
  localparam int unsigned RXW = 16 + $clog2(PERIOD + 1);
  localparam int unsigned DW  = $clog2(DRAIN_MAX + 1);

  gen_state_t     state, state_nxt;
  logic [15:0]    bursts, burst_idx;
  logic [PW-1:0]  pos;
  logic [IW-1:0]  pid;
  logic [DW-1:0]  drain_cnt;
  logic [RXW-1:0] expected, rx_count;
  logic           accept, last_cycle, drain_exit, run_ok;

  assign accept     = start && (state == GEN_IDLE || state == GEN_DONE);
  assign last_cycle = (state == GEN_SEND) && (burst_idx == bursts - 16'd1) &&
                      (pos == PW'(PERIOD - 1));
  assign expected   = RXW'(bursts) * RXW'(PERIOD - GAP_LEN);
  assign drain_exit = (rx_count == expected) || (drain_cnt == DW'(DRAIN_MAX - 1));
  assign run_ok     = locked && (err_count == '0) && (rx_count == expected);
  assign busy       = (state == GEN_SEND) || (state == GEN_DRAIN);
  assign done       = (state == GEN_DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      GEN_IDLE, GEN_DONE:
        if (start) state_nxt = (burst_count == 16'd0) ? GEN_DONE : GEN_SEND;
      GEN_SEND:
        if (last_cycle) state_nxt = GEN_DRAIN;
      GEN_DRAIN:
        if (drain_exit) state_nxt = GEN_DONE;
      default:
        state_nxt = GEN_IDLE;
    endcase
  end

  always_ff @(posedge clk_2f or posedge reset) begin
    if (reset) state <= GEN_IDLE;
    else       state <= state_nxt;
  end

  // k is held as (burst_idx, k % PERIOD, k % PAT_LEN) so no wide divider is needed.
  always_ff @(posedge clk_2f or posedge reset) begin
    if (reset) begin
      bursts    <= '0;
      burst_idx <= '0;
      pos       <= '0;
      pid       <= '0;
      drain_cnt <= '0;
      pass      <= 1'b0;
    end else if (accept) begin
      bursts    <= burst_count;
      burst_idx <= '0;
      pos       <= '0;
      pid       <= '0;
      drain_cnt <= '0;
      pass      <= 1'b0;
    end else begin
      case (state)
        GEN_SEND: begin
          pos <= (pos == PW'(PERIOD - 1)) ? '0 : pos + 1'b1;
          pid <= (pid == IW'(PAT_LEN - 1)) ? '0 : pid + 1'b1;
          if (pos == PW'(PERIOD - 1))
            burst_idx <= burst_idx + 16'd1;
        end
        GEN_DRAIN: begin
          drain_cnt <= drain_cnt + 1'b1;
          if (drain_exit)
            pass <= run_ok;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_2f or posedge reset) begin
    if (reset) begin
      phy.data_in  <= '0;
      phy.valid_in <= 1'b0;
    end else if (state == GEN_SEND) begin
      phy.data_in  <= {(DATA_W/4){pat_nibble(32'(pid))}};
      phy.valid_in <= !is_gap(32'(pos), GAP_START, GAP_LEN);
    end else begin
      phy.data_in  <= '0;
      phy.valid_in <= 1'b0;
    end
  end

  phy_bist_checker #(
    .DATA_W    (DATA_W),
    .PAT_LEN   (PAT_LEN),
    .PERIOD    (PERIOD),
    .GAP_START (GAP_START),
    .GAP_LEN   (GAP_LEN),
    .ERR_W     (ERR_W),
    .RXW       (RXW)
  ) u_checker (
    .clk       (clk_2f),
    .rst       (reset),
    .clr       (accept),
    .en        (busy),
    .data      (phy.data_out),
    .valid     (phy.valid_out),
    .expected  (expected),
    .locked    (locked),
    .rx_count  (rx_count),
    .err_count (err_count)
`ifdef PHY_BIST_ERRLOG_EN
    ,
    .first_exp (first_exp),
    .first_got (first_got),
    .first_idx (first_idx)
`endif
  );

endmodule

// File: tb/tb_phy_traffic_bist.sv
// Self-checking bench for phy_traffic_bist: loopback return path with optional junk,
// corruption and drops, checked against a stream-level reference model.
module tb_phy_traffic_bist;

  localparam int DATA_W    = 32;
  localparam int PAT_LEN   = 4;
  localparam int PERIOD    = 8;
  localparam int GAP_START = 4;
  localparam int GAP_LEN   = 2;
  localparam int DRAIN_MAX = 256;
  localparam int VPB       = PERIOD - GAP_LEN;

  logic        clk_2f = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] burst_count = '0;
  logic        busy, done, locked, pass;
  logic [15:0] err_count;
`ifdef PHY_BIST_ERRLOG_EN
  logic [31:0] first_exp, first_got;
  logic [15:0] first_idx;
`endif

  phy_traffic_bist_if #(.DATA_W(DATA_W)) bus ();

  phy_traffic_bist #(
    .DATA_W    (DATA_W),
    .PAT_LEN   (PAT_LEN),
    .PERIOD    (PERIOD),
    .GAP_START (GAP_START),
    .GAP_LEN   (GAP_LEN),
    .ERR_W     (16),
    .DRAIN_MAX (DRAIN_MAX)
  ) dut (
    .clk_2f      (clk_2f),
    .reset       (reset),
    .start       (start),
    .burst_count (burst_count),
    .phy         (bus.master),
    .busy        (busy),
    .done        (done),
    .locked      (locked),
    .pass        (pass),
    .err_count   (err_count)
`ifdef PHY_BIST_ERRLOG_EN
    ,
    .first_exp   (first_exp),
    .first_got   (first_got),
    .first_idx   (first_idx)
`endif
  );

  always #5 clk_2f = ~clk_2f;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pat(input int k);
    logic [3:0] nib;
    nib = 4'hF - 4'(k % PAT_LEN);
    return {(DATA_W/4){nib}};
  endfunction

  function automatic bit gap(input int k);
    int p;
    p = k % PERIOD;
    return (p >= GAP_START) && (p < GAP_START + GAP_LEN);
  endfunction

  typedef struct {
    logic        v;
    logic [31:0] d;
  } ent_t;

  bit          reload = 0;
  bit          noret = 0;
  int          lat = 3, junk = 0, corrupt_idx = -1, drop_pct = 0, corr_pct = 0;
  ent_t        rq[$];
  logic [31:0] seen[$];
  logic [31:0] txq[$];

  // Return path: a FIFO whose preload sets latency and leading junk words.
  initial begin
    ent_t e, o;
    int   nout;
    nout = 0;
    bus.data_out  = '0;
    bus.valid_out = 1'b0;
    forever begin
      @(posedge clk_2f);
      #1;
      if (reload) begin
        rq.delete();
        seen.delete();
        txq.delete();
        nout = 0;
        for (int i = 0; i < junk; i++) begin
          e.v = 1'b1;
          e.d = 32'($urandom_range(1, 255));
          if (junk == 5) e.d = 32'h0000_0001;
          rq.push_back(e);
        end
        for (int i = 0; i < lat; i++) begin
          e.v = 1'b0;
          e.d = '0;
          rq.push_back(e);
        end
        reload = 0;
      end
      e.v = bus.valid_in;
      e.d = bus.data_in;
      if (e.v) txq.push_back(e.d);
      if (noret) e.v = 1'b0;
      if (e.v && drop_pct > 0 && ($urandom % 100) < drop_pct) e.v = 1'b0;
      rq.push_back(e);
      o = rq.pop_front();
      if (o.v) begin
        if (nout == corrupt_idx)
          o.d[0] = ~o.d[0];
        else if (corr_pct > 0 && ($urandom % 100) < corr_pct)
          o.d[$urandom_range(0, 31)] = ~o.d[$urandom_range(0, 31)];
        seen.push_back(o.d);
        nout++;
      end
      bus.valid_out = o.v;
      bus.data_out  = o.v ? o.d : '0;
    end
  end

  // Reference: lock on the first all-F word, then compare the rest index-by-index
  // against the non-gap pattern stream; anything past the expected total is an error.
  task automatic ref_model(input int b, output bit r_lock, output int r_err, output bit r_pass,
                           output logic [31:0] f_exp, output logic [31:0] f_got,
                           output int f_idx);
    logic [31:0] ext[$];
    int          total, la, rx;
    bit          first;
    total = b * VPB;
    la = -1;
    rx = 0;
    first = 0;
    r_lock = 0;
    r_err = 0;
    f_exp = '0;
    f_got = '0;
    f_idx = 0;
    for (int k = 0; ext.size() < seen.size() + 2; k++)
      if (!gap(k)) ext.push_back(pat(k));
    for (int i = 0; i < seen.size(); i++)
      if (seen[i] == pat(0)) begin
        la = i;
        break;
      end
    if (la >= 0) begin
      r_lock = 1;
      rx = seen.size() - la;
      for (int jj = 1; jj < rx; jj++)
        if (jj >= total || seen[la+jj] != ext[jj]) begin
          r_err++;
          if (!first) begin
            first = 1;
            f_exp = ext[jj];
            f_got = seen[la+jj];
            f_idx = jj;
          end
        end
    end
    r_pass = (b != 0) && r_lock && (r_err == 0) && (rx == total);
  endtask

  task automatic run(input int b, input int l, input int j, input int ci, input int dp,
                     input int cp, input bit nr, input bit poke, output int cycles);
    lat = l;
    junk = j;
    corrupt_idx = ci;
    drop_pct = dp;
    corr_pct = cp;
    noret = nr;
    reload = 1;
    @(negedge clk_2f);
    @(negedge clk_2f);
    burst_count = 16'(b);
    start = 1'b1;
    @(negedge clk_2f);
    start = 1'b0;
    cycles = 1;
    while (!done && cycles < 3000) begin
      if (poke && cycles == 3) begin
        start = 1'b1;
        burst_count = 16'd9;
      end else begin
        start = 1'b0;
      end
      @(negedge clk_2f);
      cycles++;
    end
    start = 1'b0;
    check("done_reached", done, 1'b1);
  endtask

  task automatic verify(input string name, input int b, input int exp_cycles, input int cycles);
    bit          r_lock, r_pass;
    int          r_err;
    logic [31:0] f_exp, f_got;
    int          f_idx, k, i;
    ref_model(b, r_lock, r_err, r_pass, f_exp, f_got, f_idx);
    check({name, "_pass"}, pass, r_pass);
    check({name, "_err"}, err_count, r_err);
    check({name, "_locked"}, locked, r_lock);
    check({name, "_txcount"}, txq.size(), b * VPB);
    k = 0;
    i = 0;
    while (i < txq.size() && i < b * VPB) begin
      if (!gap(k)) begin
        check({name, "_txword"}, txq[i], pat(k));
        i++;
      end
      k++;
    end
    if (exp_cycles >= 0) check({name, "_cycles"}, cycles, exp_cycles);
`ifdef PHY_BIST_ERRLOG_EN
    check({name, "_first_exp"}, first_exp, f_exp);
    check({name, "_first_got"}, first_got, f_got);
    check({name, "_first_idx"}, first_idx, f_idx);
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cycles, b;
    reset = 1'b1;
    repeat (3) @(negedge clk_2f);
    check("reset_outputs", {busy, done, locked, pass, err_count, bus.valid_in, bus.data_in}, '0);
    reset = 1'b0;
    @(negedge clk_2f);

    // Clean loopback, two bursts.
    run(2, 3, 0, -1, 0, 0, 0, 0, cycles);
    verify("t1", 2, -1, cycles);
    check("t1_pass_const", pass, 1'b1);
    check("t1_err_const", err_count, 16'd0);

    // Third returned word corrupted.
    run(2, 3, 0, 2, 0, 0, 0, 0, cycles);
    verify("t2", 2, -1, cycles);
    check("t2_err_const", err_count, 16'd1);
    check("t2_pass_const", pass, 1'b0);

    // Five junk words ahead of the stream.
    run(2, 3, 5, -1, 0, 0, 0, 0, cycles);
    verify("t3", 2, -1, cycles);
    check("t3_pass_const", pass, 1'b1);

    // No return traffic: full drain timeout.
    run(2, 3, 0, -1, 0, 0, 1, 0, cycles);
    verify("t4", 2, 1 + 2 * PERIOD + DRAIN_MAX, cycles);
    check("t4_locked_const", locked, 1'b0);

    // Reset while sending at k=5, then a fresh clean run.
    lat = 3; junk = 0; corrupt_idx = -1; drop_pct = 0; corr_pct = 0; noret = 0;
    reload = 1;
    @(negedge clk_2f);
    @(negedge clk_2f);
    burst_count = 16'd2;
    start = 1'b1;
    @(negedge clk_2f);
    start = 1'b0;
    repeat (5) @(negedge clk_2f);
    check("t5_busy_before", busy, 1'b1);
    reset = 1'b1;
    @(negedge clk_2f);
    check("t5_reset_outputs", {busy, done, locked, pass, err_count, bus.valid_in, bus.data_in}, '0);
    reset = 1'b0;
    @(negedge clk_2f);
    run(2, 3, 0, -1, 0, 0, 0, 0, cycles);
    verify("t5", 2, -1, cycles);

    // Zero bursts, then a start pulse during SEND that must be ignored.
    run(0, 3, 0, -1, 0, 0, 0, 0, cycles);
    verify("t6z", 0, 1, cycles);
    run(2, 3, 0, -1, 0, 0, 0, 1, cycles);
    verify("t6p", 2, -1, cycles);
    check("t6p_pass_const", pass, 1'b1);

    for (int r = 0; r < 8; r++) begin
      b = $urandom_range(1, 5);
      run(b, $urandom_range(1, 5), $urandom_range(0, 3), -1,
          (r % 3 == 2) ? 10 : 0, (r % 2 == 1) ? 8 : 0, 0, 0, cycles);
      verify("rnd", b, -1, cycles);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
